mul_share_arbiter: RTL and testbench

//  Shares one combinational 4x4 unsigned array multiplier among NREQ requesters.

---
 rtl/mul_share_pkg.sv | 31 +++
 rtl/mul4x4_comb.sv | 22 ++
 rtl/mul_share_arbiter.sv | 74 +++++++
 tb/tb_mul_share_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// rr_pick is sized for up to 8 requesters; callers pad valid/ptr to 8/3 bits.
package mul_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // First set bit of valid, searching ptr, ptr+1, ... wrapping at nreq.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         nreq);
        logic       found;
        logic [3:0] j;
        found   = 1'b0;
        rr_pick = '0;
        for (int k = 0; k < 8; k++) begin
            j = 4'(ptr) + 4'(k);
            if (j >= 4'(nreq)) j = j - 4'(nreq);
            if (!found && (k < nreq) && valid[j[2:0]]) begin
                found   = 1'b1;
                rr_pick = j[2:0];
            end
        end
    endfunction

endpackage

// File: rtl/mul4x4_comb.sv
// Combinational unsigned partial-product array multiplier.
// One shifted copy of a per bit of b, summed into the full 2*W product.
module mul4x4_comb #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [W-1:0][2*W-1:0] pp;

    for (genvar i = 0; i < W; i++) begin : g_pp
        assign pp[i] = b[i] ? ({{W{1'b0}}, a} << i) : '0;
    end

    always_comb begin
        p = '0;
        for (int i = 0; i < W; i++) p = p + pp[i];
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among NREQ clients,
// with a one-entry registered result buffer tagged by requester ID.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [2*W-1:0]    rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic [CNTW-1:0]   op_count
);

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_idx;
    logic            can_accept;
    logic            gnt;
    logic [W-1:0]    a_g, b_g;
    logic [2*W-1:0]  prod;

    assign rsp_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) || (rsp_valid && rsp_ready);
    // Gated by rst so no operand pair is consumed while resetting.
    assign gnt        = can_accept && (|req_valid) && !rst;
    assign gnt_idx    = IDW'(rr_pick(8'(req_valid), 3'(rr_ptr), NREQ));
    assign req_ready  = gnt ? (NREQ'(1) << gnt_idx) : '0;

    assign a_g = req_a[gnt_idx*W +: W];
    assign b_g = req_b[gnt_idx*W +: W];

    mul4x4_comb #(.W(W)) u_mul (
        .a (a_g),
        .b (b_g),
        .p (prod)
    );

    always_comb begin
        state_nxt = state;
        if (gnt)
            state_nxt = FULL;
        else if (state == FULL && rsp_ready)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            rsp_data <= '0;
            rsp_id   <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            if (gnt) begin
                rsp_data <= prod;
                rsp_id   <= gnt_idx;
                rr_ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: handshake, round-robin order,
// backpressure, reset, exhaustive products and counter wrap.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [2*W-1:0]    rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    logic [CNTW-1:0]   op_count;

    int n_asrt = 0;
    int n_fail = 0;

    mul_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        step(); step();
        // Reset state; a valid request must not be granted while in reset
        req_valid = 4'b0001;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data",  32'(rsp_data),  32'h0);
        chk("rst_count", 32'(op_count),  32'h0);

        // 1. Single request
        rst = 1'b0; set_op(0, 15, 15); #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        step(); req_valid = '0;
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_data",  32'(rsp_data),  32'd225);
        chk("t1_id",    32'(rsp_id),    32'h0);
        chk("t1_count", 32'(op_count),  32'd1);

        // 2. All contending, from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 3);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_ready", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            chk("t2_data", 32'(rsp_data), 32'((k % 4 + 1) * 3));
            chk("t2_id",   32'(rsp_id),   32'(k % 4));
            if (k == 3) chk("t2_count4", 32'(op_count), 32'd4);
        end

        // 3. Backpressure: load 7*9 via requester 1, then hold it
        req_valid = 4'b0010; set_op(1, 7, 9); #1;
        chk("t3_ready1", 32'(req_ready), 32'b0010);
        step();
        chk("t3_data63", 32'(rsp_data), 32'd63);
        req_valid = 4'b0100; set_op(2, 2, 5); rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_stall_ready", 32'(req_ready), 32'h0);
            chk("t3_stall_data",  32'(rsp_data),  32'd63);
            chk("t3_stall_valid", 32'(rsp_valid), 32'h1);
            step();
        end
        rsp_ready = 1'b1; #1;
        chk("t3_ready2", 32'(req_ready), 32'b0100);
        step();
        chk("t3_valid", 32'(rsp_valid), 32'h1);
        chk("t3_data",  32'(rsp_data),  32'd10);
        chk("t3_id",    32'(rsp_id),    32'd2);

        // 4. Pointer fairness after a grant to 3
        req_valid = 4'b1000; set_op(3, 4, 4); #1;
        chk("t4_ready3", 32'(req_ready), 32'b1000);
        step();
        chk("t4_data16", 32'(rsp_data), 32'd16);
        req_valid = 4'b1001; set_op(0, 2, 2); #1;
        chk("t4_ready0", 32'(req_ready), 32'b0001);
        step();
        chk("t4_id0", 32'(rsp_id), 32'd0);
        req_valid = 4'b1000; set_op(3, 5, 3); #1;
        chk("t4_ready3b", 32'(req_ready), 32'b1000);
        step();
        chk("t4_data15", 32'(rsp_data), 32'd15);
        chk("t4_id3",    32'(rsp_id),   32'd3);
        req_valid = '0;
        step();
        chk("drain_valid", 32'(rsp_valid), 32'h0);
        chk("drain_count", 32'(op_count),  32'd10);

        // 5. Reset while FULL with 0x2A held
        req_valid = 4'b0001; set_op(0, 6, 7); rsp_ready = 1'b0;
        step();
        chk("t5_data2a", 32'(rsp_data), 32'h2A);
        rst = 1'b1;
        step();
        chk("t5_valid", 32'(rsp_valid), 32'h0);
        chk("t5_data",  32'(rsp_data),  32'h0);
        chk("t5_id",    32'(rsp_id),    32'h0);
        chk("t5_count", 32'(op_count),  32'h0);
        chk("t5_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;

        // 6. Exhaustive through port 1, then drive op_count to wrap
        req_valid = 4'b0010; rsp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_op(1, a, b);
                step();
                chk("t6_prod", 32'(rsp_data), 32'(a * b));
            end
        end
        chk("t6_id", 32'(rsp_id), 32'd1);
        chk("t6_count256", 32'(op_count), 32'd256);
        for (int k = 0; k < 65535 - 256; k++) step();
        chk("t6_countmax", 32'(op_count), 32'hFFFF);
        step();
        chk("t6_wrap", 32'(op_count), 32'h0);
        req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
